// File: rtl/hart_reset_ctrl.sv
// hart_reset_ctrl: debug-module driven reset sequencer.
// One FSM per hart (IDLE/HOLD/DONE) plus a system FSM (IDLE/HOLD/WAIT/DONE)
// that gates the peripheral reset. Every output is a flop loaded from the
// next-state decode, so a request sampled in cycle t shows up in cycle t+1.
// Optional feature macro: HART_RESET_CTRL_STATUS_EN adds the sticky
// per-hart hart_reset_seen status with its clear input.
module hart_reset_ctrl #(
    parameter int unsigned N_HARTS     = 1,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_reset_req,
    input  logic [N_HARTS-1:0] hart_reset_req,
`ifdef HART_RESET_CTRL_STATUS_EN
    input  logic [N_HARTS-1:0] hart_reset_seen_clr,
    output logic [N_HARTS-1:0] hart_reset_seen,
`endif
    output logic [N_HARTS-1:0] rst_n_hart,
    output logic               rst_n_periph,
    output logic [N_HARTS-1:0] hart_reset_done,
    output logic               sys_reset_done
);

    localparam int unsigned   CW      = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        H_IDLE,
        H_HOLD,
        H_DONE
    } hart_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT,
        S_DONE
    } sys_state_e;

    // Harts whose FSM will be in HOLD next cycle; the system FSM uses this
    // so its done pulse lines up with the last hart leaving HOLD.
    logic [N_HARTS-1:0] hold_next;

    for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
        hart_state_e   state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          eff;
        logic          rst_n_q, done_q;

        assign eff = hart_reset_req[i] | sys_reset_req;

        // Hart next-state: a request during HOLD only extends the hold.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                H_IDLE: begin
                    if (eff) begin
                        state_d = H_HOLD;
                        cnt_d   = '0;
                    end
                end
                H_HOLD: begin
                    if (cnt_q == CNT_MAX && !eff) begin
                        state_d = H_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                H_DONE: begin
                    cnt_d   = '0;
                    state_d = eff ? H_HOLD : H_IDLE;
                end
                default: begin
                    state_d = H_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign hold_next[i] = (state_d == H_HOLD);

        // Hart state and registered outputs; reset forces a fresh hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= H_HOLD;
                cnt_q   <= '0;
                rst_n_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rst_n_q <= (state_d != H_HOLD);
                done_q  <= (state_d == H_DONE);
            end
        end

        assign rst_n_hart[i]      = rst_n_q;
        assign hart_reset_done[i] = done_q;

`ifdef HART_RESET_CTRL_STATUS_EN
        logic seen_q;

        // Sticky completion flag; a completion in the clear cycle wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                seen_q <= 1'b0;
            end else if (state_q == H_DONE) begin
                seen_q <= 1'b1;
            end else if (hart_reset_seen_clr[i]) begin
                seen_q <= 1'b0;
            end
        end

        assign hart_reset_seen[i] = seen_q;
`endif
    end

    sys_state_e    sstate_q, sstate_d;
    logic [CW-1:0] scnt_q, scnt_d;
    logic          rst_n_periph_q, sys_done_q;

    // System next-state: after its own hold, wait for every hart to finish.
    always_comb begin
        sstate_d = sstate_q;
        scnt_d   = scnt_q;
        case (sstate_q)
            S_IDLE: begin
                if (sys_reset_req) begin
                    sstate_d = S_HOLD;
                    scnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (scnt_q == CNT_MAX && !sys_reset_req) begin
                    sstate_d = (|hold_next) ? S_WAIT : S_DONE;
                    scnt_d   = '0;
                end else if (scnt_q != CNT_MAX) begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (sys_reset_req) begin
                    sstate_d = S_HOLD;
                    scnt_d   = '0;
                end else if (!(|hold_next)) begin
                    sstate_d = S_DONE;
                end
            end
            S_DONE: begin
                scnt_d   = '0;
                sstate_d = sys_reset_req ? S_HOLD : S_IDLE;
            end
            default: begin
                sstate_d = S_IDLE;
                scnt_d   = '0;
            end
        endcase
    end

    // System state and registered peripheral reset / done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sstate_q       <= S_HOLD;
            scnt_q         <= '0;
            rst_n_periph_q <= 1'b0;
            sys_done_q     <= 1'b0;
        end else begin
            sstate_q       <= sstate_d;
            scnt_q         <= scnt_d;
            rst_n_periph_q <= !(sstate_d == S_HOLD || sstate_d == S_WAIT);
            sys_done_q     <= (sstate_d == S_DONE);
        end
    end

    assign rst_n_periph   = rst_n_periph_q;
    assign sys_reset_done = sys_done_q;

endmodule

// File: tb/tb_hart_reset_ctrl.sv
// Testbench for hart_reset_ctrl (N_HARTS=4, HOLD_CYCLES=16): directed timing
// scenarios plus random traffic compared against a cycle-level model.
module tb_hart_reset_ctrl;

    localparam int NH = 4;
    localparam int HC = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          sys_reset_req;
    logic [NH-1:0] hart_reset_req;
    logic [NH-1:0] rst_n_hart;
    logic          rst_n_periph;
    logic [NH-1:0] hart_reset_done;
    logic          sys_reset_done;
`ifdef HART_RESET_CTRL_STATUS_EN
    logic [NH-1:0] hart_reset_seen_clr;
    logic [NH-1:0] hart_reset_seen;
`endif

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    always #5 clk = ~clk;

    hart_reset_ctrl #(
        .N_HARTS    (NH),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sys_reset_req      (sys_reset_req),
        .hart_reset_req     (hart_reset_req),
`ifdef HART_RESET_CTRL_STATUS_EN
        .hart_reset_seen_clr(hart_reset_seen_clr),
        .hart_reset_seen    (hart_reset_seen),
`endif
        .rst_n_hart         (rst_n_hart),
        .rst_n_periph       (rst_n_periph),
        .hart_reset_done    (hart_reset_done),
        .sys_reset_done     (sys_reset_done)
    );

    // Reference model: "holding" flag with an unbounded age, a pulse flag,
    // and for the system a "waiting for harts" flag.
    bit m_h_hold [NH];
    int m_h_age  [NH];
    bit m_h_pulse[NH];
    bit m_seen   [NH];
    bit m_s_hold, m_s_wait, m_s_pulse;
    int m_s_age;

    task automatic model_update();
        bit any_hold;
        bit eff;
        if (rst) begin
            for (int i = 0; i < NH; i++) begin
                m_h_hold[i] = 1; m_h_age[i] = 0; m_h_pulse[i] = 0; m_seen[i] = 0;
            end
            m_s_hold = 1; m_s_wait = 0; m_s_pulse = 0; m_s_age = 0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                eff = hart_reset_req[i] | sys_reset_req;
`ifdef HART_RESET_CTRL_STATUS_EN
                if (m_h_pulse[i]) m_seen[i] = 1;
                else if (hart_reset_seen_clr[i]) m_seen[i] = 0;
`endif
                if (m_h_hold[i]) begin
                    if (m_h_age[i] >= HC - 1 && !eff) begin
                        m_h_hold[i] = 0; m_h_pulse[i] = 1;
                    end else begin
                        m_h_age[i]++;
                    end
                end else begin
                    m_h_pulse[i] = 0;
                    if (eff) begin m_h_hold[i] = 1; m_h_age[i] = 0; end
                end
            end
            any_hold = 0;
            for (int i = 0; i < NH; i++) any_hold |= m_h_hold[i];
            if (m_s_hold) begin
                if (m_s_age >= HC - 1 && !sys_reset_req) begin
                    m_s_hold = 0;
                    if (any_hold) m_s_wait = 1; else m_s_pulse = 1;
                end else begin
                    m_s_age++;
                end
            end else if (m_s_wait) begin
                if (sys_reset_req) begin
                    m_s_wait = 0; m_s_hold = 1; m_s_age = 0;
                end else if (!any_hold) begin
                    m_s_wait = 0; m_s_pulse = 1;
                end
            end else begin
                m_s_pulse = 0;
                if (sys_reset_req) begin m_s_hold = 1; m_s_age = 0; end
            end
        end
    endtask

    // Model outputs packed as {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}.
    function automatic logic [2*NH+1:0] model_vec();
        logic [NH-1:0] rn, hd;
        for (int i = 0; i < NH; i++) begin
            rn[i] = !m_h_hold[i];
            hd[i] = m_h_pulse[i];
        end
        return {rn, hd, !(m_s_hold || m_s_wait), m_s_pulse};
    endfunction

    function automatic logic [NH-1:0] model_seen();
        logic [NH-1:0] s;
        for (int i = 0; i < NH; i++) s[i] = m_seen[i];
        return s;
    endfunction

    // One clock: inputs are stable at the edge, model follows, sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        logic [2*NH+1:0] exp;
        rst = 1; sys_reset_req = 0; hart_reset_req = '0;
`ifdef HART_RESET_CTRL_STATUS_EN
        hart_reset_seen_clr = '0;
`endif
        repeat (3) tick();
        chk_cnt++;
        if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== '0)
            $display("FAIL reset_hold got=%b exp=%b",
                     {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, {(2*NH+2){1'b0}});
        else pass_cnt++;
        rst = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp = (n <= 15) ? {4'b0000, 4'b0000, 1'b0, 1'b0}
                : (n == 16) ? {4'b1111, 4'b1111, 1'b1, 1'b1}
                            : {4'b1111, 4'b0000, 1'b1, 1'b0};
            chk_cnt++;
            if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== exp)
                $display("FAIL reset_release t+%0d got=%b exp=%b", n,
                         {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_hart_pulse();
        logic [NH-1:0] rn, hd;
        for (int n = 1; n <= 19; n++) begin
            hart_reset_req = (n == 1) ? 4'b0010 : 4'b0000;
            tick();
            rn = 4'b1111;
            if (n <= 16) rn[1] = 1'b0;
            hd = (n == 17) ? 4'b0010 : 4'b0000;
            chk_cnt++;
            if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== {rn, hd, 1'b1, 1'b0})
                $display("FAIL hart1_pulse t+%0d got=%b exp=%b", n,
                         {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, {rn, hd, 1'b1, 1'b0});
            else pass_cnt++;
        end
    endtask

    task automatic test_long_hold();
        logic [NH-1:0] rn, hd;
        for (int n = 1; n <= 44; n++) begin
            hart_reset_req = (n <= 40) ? 4'b0001 : 4'b0000;
            tick();
            rn = 4'b1111;
            if (n <= 40) rn[0] = 1'b0;
            hd = (n == 41) ? 4'b0001 : 4'b0000;
            chk_cnt++;
            if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== {rn, hd, 1'b1, 1'b0})
                $display("FAIL hart0_long t+%0d got=%b exp=%b", n,
                         {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, {rn, hd, 1'b1, 1'b0});
            else pass_cnt++;
        end
    endtask

    // sys request lands while hart 2 is at count 10; second pass keeps hart 2
    // requested long enough that the system sequence must sit in WAIT.
    task automatic test_sys_during_hold();
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 1; n <= 45; n++) begin
                hart_reset_req = 4'b0000;
                if (n == 1 || (pass == 1 && n <= 31)) hart_reset_req[2] = 1'b1;
                sys_reset_req = (n == 12);
                tick();
                chk_cnt++;
                if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== model_vec())
                    $display("FAIL sys_overlap p%0d t+%0d got=%b exp=%b", pass, n,
                             {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, model_vec());
                else pass_cnt++;
                if (pass == 0 && n == 17) begin
                    chk_cnt++;
                    if (hart_reset_done[2] !== 1'b1)
                        $display("FAIL hart2_not_restarted got=%b exp=1", hart_reset_done[2]);
                    else pass_cnt++;
                end
                if (n == (pass == 0 ? 28 : 32)) begin
                    chk_cnt++;
                    if (sys_reset_done !== 1'b1)
                        $display("FAIL sys_done_time p%0d got=%b exp=1", pass, sys_reset_done);
                    else pass_cnt++;
                end
                if (pass == 1 && n == 30) begin
                    chk_cnt++;
                    if ({rst_n_periph, sys_reset_done} !== 2'b00)
                        $display("FAIL sys_wait got=%b exp=00", {rst_n_periph, sys_reset_done});
                    else pass_cnt++;
                end
            end
        end
        sys_reset_req = 0;
    endtask

    task automatic test_done_reassert();
        for (int n = 1; n <= 37; n++) begin
            hart_reset_req = (n == 1 || n == 18) ? 4'b1000 : 4'b0000;
            tick();
            chk_cnt++;
            if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== model_vec())
                $display("FAIL hart3_redo t+%0d got=%b exp=%b", n,
                         {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, model_vec());
            else pass_cnt++;
            if (n == 17 || n == 18 || n == 33 || n == 34) begin
                chk_cnt++;
                if ({rst_n_hart[3], hart_reset_done[3]} !== ((n == 17 || n == 34) ? 2'b11 : 2'b00))
                    $display("FAIL hart3_redo_edge t+%0d got=%b exp=%b", n,
                             {rst_n_hart[3], hart_reset_done[3]}, ((n == 17 || n == 34) ? 2'b11 : 2'b00));
                else pass_cnt++;
            end
        end
    endtask

`ifdef HART_RESET_CTRL_STATUS_EN
    task automatic test_status();
        for (int n = 1; n <= 22; n++) begin
            hart_reset_req      = (n == 1) ? 4'b0100 : 4'b0000;
            hart_reset_seen_clr = (n == 18 || n == 20) ? 4'b0100 : 4'b0000;
            tick();
            chk_cnt++;
            if (hart_reset_seen !== model_seen())
                $display("FAIL seen t+%0d got=%b exp=%b", n, hart_reset_seen, model_seen());
            else pass_cnt++;
            if (n == 18) begin
                chk_cnt++;
                if (hart_reset_seen[2] !== 1'b1)
                    $display("FAIL seen_set_wins got=%b exp=1", hart_reset_seen[2]);
                else pass_cnt++;
            end
        end
        hart_reset_seen_clr = '0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            sys_reset_req = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NH; i++)
                if ($urandom_range(0, 11) == 0) hart_reset_req[i] = ~hart_reset_req[i];
`ifdef HART_RESET_CTRL_STATUS_EN
            for (int i = 0; i < NH; i++)
                hart_reset_seen_clr[i] = ($urandom_range(0, 7) == 0);
`endif
            tick();
            chk_cnt++;
            if ({rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done} !== model_vec())
                $display("FAIL random step=%0d got=%b exp=%b", n,
                         {rst_n_hart, hart_reset_done, rst_n_periph, sys_reset_done}, model_vec());
            else pass_cnt++;
`ifdef HART_RESET_CTRL_STATUS_EN
            chk_cnt++;
            if (hart_reset_seen !== model_seen())
                $display("FAIL random_seen step=%0d got=%b exp=%b", n, hart_reset_seen, model_seen());
            else pass_cnt++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_hart_pulse();
        test_long_hold();
        test_sys_during_hold();
        test_done_reassert();
`ifdef HART_RESET_CTRL_STATUS_EN
        test_status();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hart_reset_ctrl.md
HART_RESET_CTRL -- requirements
Module: hart_reset_ctrl

Interface
- REQ-001 SHALL have parameter N_HARTS, default 1: number of harts, legal 1..32.
- REQ-002 SHALL have parameter HOLD_CYCLES, default 16: minimum reset assertion length in cycles, legal 2..256.
- REQ-003 SHALL have port clk, input, 1: the single clock.
- REQ-004 SHALL have port rst, input, 1: synchronous active-high block reset, the upstream system reset.
- REQ-005 SHALL have port sys_reset_req, input, 1: level request from the DM for a system reset.
- REQ-006 SHALL have port hart_reset_req, input, N_HARTS: per-hart level reset requests from the DM.
- REQ-007 SHALL have port rst_n_hart, output, N_HARTS: per-hart active-low reset to each CPU.
- REQ-008 SHALL have port rst_n_periph, output, 1: active-low reset to the bus fabric and peripherals.
- REQ-009 SHALL have port hart_reset_done, output, N_HARTS: one-cycle pulse per completed hart sequence.
- REQ-010 SHALL have port sys_reset_done, output, 1: one-cycle pulse per completed system sequence.

Function
- REQ-011 SHALL register all outputs; a request sampled in cycle t affects the outputs in cycle t+1.
- REQ-012 SHALL give each hart i its own FSM with states IDLE, HOLD and DONE and its own counter, width $clog2(HOLD_CYCLES).
- REQ-013 SHALL define the effective request for hart i as eff[i] = hart_reset_req[i] | sys_reset_req.
- REQ-014 SHALL make each hart FSM move IDLE->HOLD on eff[i]=1 with counter=0.
- REQ-015 SHALL, in HOLD, increment the counter, saturating at HOLD_CYCLES-1.
- REQ-016 SHALL move a hart FSM HOLD->DONE only when counter==HOLD_CYCLES-1 and eff[i]=0.
- REQ-017 SHALL make each hart FSM leave DONE after exactly one cycle: to HOLD with counter=0 if eff[i]=1, else to IDLE.
- REQ-018 SHALL drive rst_n_hart[i]=0 exactly while hart FSM i is in HOLD.
- REQ-019 SHALL drive hart_reset_done[i]=1 exactly while hart FSM i is in DONE.
- REQ-020 SHALL not restart or clear a hart counter already in HOLD when eff[i] rises again; it only extends the hold.
- REQ-021 SHALL implement the system FSM with states IDLE, HOLD, WAIT and DONE, and its own counter.
- REQ-022 SHALL apply the same IDLE/HOLD/counter rules to the system FSM using sys_reset_req.
- REQ-023 SHALL move the system FSM from HOLD on exit to DONE if no hart FSM is in HOLD in that cycle, else to WAIT.
- REQ-024 SHALL move the system FSM WAIT->DONE in the first cycle in which no hart FSM is in HOLD.
- REQ-025 SHALL drive rst_n_periph=0 while the system FSM is in HOLD or WAIT.
- REQ-026 SHALL drive sys_reset_done=1 exactly while the system FSM is in DONE.
- REQ-027 SHALL guarantee at least one cycle of done=0 between successive done pulses, with no stale level carried between sequences.
- REQ-028 SHALL keep hart FSMs fully independent; a request on one hart never affects another hart's outputs.

Reset
- REQ-029 SHALL, while rst=1, force all FSMs to HOLD with counter 0 and drive rst_n_hart=0, rst_n_periph=0 and all done outputs=0.
- REQ-030 SHALL, after rst falls, run a normal sequence: release after HOLD_CYCLES, with done pulses emitted.
- REQ-031 SHALL let rst asserted mid-sequence override any state in the next cycle.

Configuration
- REQ-032 SHALL, with macro HART_RESET_CTRL_STATUS_EN defined, add input hart_reset_seen_clr[N_HARTS] and output hart_reset_seen[N_HARTS].
- REQ-033 SHALL, with that macro, set a sticky hart_reset_seen[i] when FSM i is in DONE and clear it on hart_reset_seen_clr[i]; set wins over clear; reset value 0.
- REQ-034 SHALL, without HART_RESET_CTRL_STATUS_EN, omit both ports and all their logic.

Verification (N_HARTS=4, HOLD_CYCLES=16)
- REQ-035 SHALL cover: rst high 3 cycles then low at t -> all rst_n low through t+15, high at t+16; each done pulses once at t+16.
- REQ-036 SHALL cover: hart_reset_req[1] one-cycle pulse at t -> rst_n_hart[1] low t+1..t+16, hart_reset_done[1] high only at t+17; other harts and rst_n_periph stay high.
- REQ-037 SHALL cover: hart_reset_req[0] high t..t+39 -> rst_n_hart[0] low t+1..t+40, done pulse at t+41.
- REQ-038 SHALL cover: sys_reset_req pulse while hart 2's counter=10 -> hart 2 is not restarted; harts 0,1,3 hold 16 cycles; sys_reset_done waits in WAIT until hart 2 leaves HOLD.
- REQ-039 SHALL cover: eff[3] reasserted during DONE -> done pulses that cycle and the FSM re-enters HOLD the next cycle with counter 0.
- REQ-040 SHALL cover, with HART_RESET_CTRL_STATUS_EN: hart_reset_seen_clr[2] asserted in the same cycle as hart 2 DONE -> hart_reset_seen[2]=1.
